// File: rtl/axis_pattern_gen.sv
// axis_pattern_gen: AXI-Stream traffic source.
// Sends bursts of num_pkts packets of pkt_len beats each.
// tdata starts at seed and counts up by one per transferred beat.
// tlast marks the final beat of every packet.
// Optional IFG_CYCLES idle cycles (tvalid low) are inserted between packets.
// Optional macro AXIS_GEN_THROTTLE_EN: a 16-bit LFSR randomly delays the
// presentation of each new beat. The data sequence is not changed.
module axis_pattern_gen #(
    parameter int AXIS_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16,
    parameter int IFG_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic [CNT_WIDTH-1:0]  num_pkts,
    input  logic [AXIS_WIDTH-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic                  m_axis_tvalid,
    output logic [AXIS_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready
);

    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = (IFG_CYCLES > 0) ? GAP_W'(IFG_CYCLES - 1) : '0;
    localparam bit HAS_GAP = (IFG_CYCLES > 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  tvalid_q, tvalid_d;
    logic [AXIS_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tlast_q, tlast_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic [CNT_WIDTH-1:0]  pkt_q, pkt_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [CNT_WIDTH-1:0]  npkt_q, npkt_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  last_beat;
    logic                  last_pkt;
    logic                  present_ok;

`ifdef AXIS_GEN_THROTTLE_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Free-running Fibonacci LFSR (taps 16,14,13,11); a new beat may only appear when bit 0 is set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
        end
    end

    assign present_ok = lfsr_q[0];
`else
    assign present_ok = 1'b1;
`endif

    assign last_beat = (beat_q == (len_q - LEN_WIDTH'(1)));
    assign last_pkt  = (pkt_q == (npkt_q - CNT_WIDTH'(1)));

    // Next-state and registered-output computation for the burst FSM
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        beat_d   = beat_q;
        pkt_d    = pkt_q;
        len_d    = len_q;
        npkt_d   = npkt_q;
        gap_d    = gap_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d  = 1'b1;
                    len_d   = pkt_len;
                    npkt_d  = num_pkts;
                    beat_d  = '0;
                    pkt_d   = '0;
                    tdata_d = seed;
                    if ((pkt_len == '0) || (num_pkts == '0)) begin
                        // Empty burst: nothing to send, just report completion
                        state_d = S_DONE;
                        tlast_d = 1'b0;
                    end else begin
                        state_d  = S_SEND;
                        tvalid_d = present_ok;
                        tlast_d  = (pkt_len == LEN_WIDTH'(1));
                    end
                end
            end

            S_SEND: begin
                if (!tvalid_q) begin
                    // Beat prepared but held back by the throttle
                    if (present_ok) begin
                        tvalid_d = 1'b1;
                    end
                end else if (m_axis_tready) begin
                    // Data keeps counting across packet boundaries
                    tdata_d = tdata_q + AXIS_WIDTH'(1);
                    if (!last_beat) begin
                        beat_d   = beat_q + LEN_WIDTH'(1);
                        tvalid_d = present_ok;
                        tlast_d  = ((beat_q + LEN_WIDTH'(1)) == (len_q - LEN_WIDTH'(1)));
                    end else if (!last_pkt) begin
                        beat_d  = '0;
                        pkt_d   = pkt_q + CNT_WIDTH'(1);
                        tlast_d = (len_q == LEN_WIDTH'(1));
                        if (HAS_GAP) begin
                            state_d  = S_GAP;
                            gap_d    = '0;
                            tvalid_d = 1'b0;
                        end else begin
                            tvalid_d = present_ok;
                        end
                    end else begin
                        state_d  = S_DONE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                    end
                end
            end

            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d  = S_SEND;
                    tvalid_d = present_ok;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any burst at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            beat_q   <= '0;
            pkt_q    <= '0;
            len_q    <= '0;
            npkt_q   <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            beat_q   <= beat_d;
            pkt_q    <= pkt_d;
            len_q    <= len_d;
            npkt_q   <= npkt_d;
            gap_q    <= gap_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Testbench for axis_pattern_gen.
// Directed and randomized bursts are checked against a packet-level model.
// The model predicts the beat sequence (seed + n, tlast every pkt_len beats).
// With tready held high it also predicts the cycle of every transfer and of done.
module tb_axis_pattern_gen;

    localparam int AW  = 32;
    localparam int IFG = 2;
`ifdef AXIS_GEN_THROTTLE_EN
    localparam bit TIMING_OK = 1'b0;
`else
    localparam bit TIMING_OK = 1'b1;
`endif

    logic          clk;
    logic          reset;
    logic          start;
    logic [15:0]   pkt_len;
    logic [15:0]   num_pkts;
    logic [AW-1:0] seed;
    logic          busy;
    logic          done;
    logic          m_axis_tvalid;
    logic [AW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          m_axis_tready;

    int checks = 0;
    int errors = 0;

    axis_pattern_gen #(
        .AXIS_WIDTH (AW),
        .LEN_WIDTH  (16),
        .CNT_WIDTH  (16),
        .IFG_CYCLES (IFG)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .pkt_len       (pkt_len),
        .num_pkts      (num_pkts),
        .seed          (seed),
        .busy          (busy),
        .done          (done),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One burst: start it, drive tready, and compare every transfer with the model
    task automatic run_burst(input string tag, input logic [AW-1:0] s, input int len,
                             input int npk, input int rdy_pct, input bit timing);
        logic [AW-1:0] exp_data[$];
        logic          exp_last[$];
        int            idx;
        int            cyc;
        int            total;
        bit            do_time;
        bit            prev_stall;
        logic [AW-1:0] prev_data;
        logic          prev_last;

        do_time = timing && TIMING_OK;
        for (int p = 0; p < npk; p++) begin
            for (int b = 0; b < len; b++) begin
                exp_data.push_back(s + AW'(p * len + b));
                exp_last.push_back(b == len - 1);
            end
        end
        total = (len * npk == 0) ? 0 : (npk * len + (npk - 1) * IFG);

        @(negedge clk);
        seed          = s;
        pkt_len       = len[15:0];
        num_pkts      = npk[15:0];
        start         = 1'b1;
        m_axis_tready = 1'b0;
        @(negedge clk);
        // Scramble inputs after capture; they must have no effect
        start    = 1'b0;
        seed     = $urandom;
        pkt_len  = 16'($urandom);
        num_pkts = 16'($urandom);
        check({tag, ":busy_after_start"}, busy, 1);

        idx        = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        while (!done && cyc < 4000) begin
            check({tag, ":busy_during"}, busy, 1);
            if (prev_stall) begin
                check({tag, ":stall_valid"}, m_axis_tvalid, 1);
                check({tag, ":stall_data"}, m_axis_tdata, prev_data);
                check({tag, ":stall_last"}, m_axis_tlast, prev_last);
            end
            m_axis_tready = ($urandom_range(99) < rdy_pct);
            start         = ($urandom_range(3) == 0);
            if (m_axis_tvalid && m_axis_tready) begin
                check({tag, ":beat_expected"}, idx < exp_data.size(), 1);
                if (idx < exp_data.size()) begin
                    check({tag, ":tdata"}, m_axis_tdata, exp_data[idx]);
                    check({tag, ":tlast"}, m_axis_tlast, exp_last[idx]);
                    if (do_time) begin
                        check({tag, ":xfer_cycle"}, cyc, idx + (idx / len) * IFG);
                    end
                end
                idx++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            @(negedge clk);
            cyc++;
        end
        start         = 1'b0;
        m_axis_tready = 1'b0;
        check({tag, ":done_seen"}, done, 1);
        check({tag, ":busy_at_done"}, busy, 0);
        check({tag, ":valid_at_done"}, m_axis_tvalid, 0);
        check({tag, ":beat_count"}, idx, exp_data.size());
        if (do_time) begin
            check({tag, ":done_cycle"}, cyc, total + 1);
        end
        $display("burst %s seed=%08h len=%0d pkts=%0d beats=%0d cycles=%0d", tag, s, len, npk, idx, cyc);
        @(negedge clk);
        check({tag, ":done_pulse_end"}, done, 0);
        check({tag, ":idle_busy"}, busy, 0);
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        pkt_len       = '0;
        num_pkts      = '0;
        seed          = '0;
        m_axis_tready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset:tvalid", m_axis_tvalid, 0);
        check("reset:busy", busy, 0);
        check("reset:done", done, 0);
        check("reset:tdata", m_axis_tdata, 0);
        check("reset:tlast", m_axis_tlast, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset:tvalid", m_axis_tvalid, 0);

        // Reset in the middle of a burst must kill tvalid/busy immediately
        seed          = 32'h0000_0100;
        pkt_len       = 16'd8;
        num_pkts      = 16'd2;
        start         = 1'b1;
        m_axis_tready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midburst:busy", busy, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset:tvalid", m_axis_tvalid, 0);
        check("async_reset:busy", busy, 0);
        check("async_reset:tdata", m_axis_tdata, 0);
        check("async_reset:tlast", m_axis_tlast, 0);
        $display("reset asserted mid-burst tvalid=%0b busy=%0b", m_axis_tvalid, busy);
        @(negedge clk);
        reset         = 1'b0;
        m_axis_tready = 1'b0;
        repeat (2) @(negedge clk);
        check("after_reset:tvalid", m_axis_tvalid, 0);
        check("after_reset:busy", busy, 0);

        // Single packet, full throughput
        run_burst("len4", 32'h10, 4, 1, 100, 1'b1);
        // Two packets separated by the inter-frame gap
        run_burst("len3x2", 32'h10, 3, 2, 100, 1'b1);
        // tlast on every beat
        run_burst("len1x3", 32'h55, 1, 3, 100, 1'b1);
        // Data wrap-around
        run_burst("wrap", 32'hFFFF_FFFF, 2, 1, 100, 1'b1);
        // Empty bursts
        run_burst("len0", 32'h20, 0, 3, 100, 1'b1);
        run_burst("pkts0", 32'h30, 5, 0, 100, 1'b1);
        // Backpressure at 50%
        for (int t = 0; t < 6; t++) begin
            run_burst("rand", $urandom, $urandom_range(1, 6), $urandom_range(1, 4), 50, 1'b0);
        end
        // Heavy backpressure on a longer burst
        run_burst("slow", $urandom, 7, 3, 25, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
